key_char_fifo: RTL

Buffers decoded keystrokes between the keyboard-to-ASCII stage and the editor core. It accepts one ASCII character per key-press strobe and generates typematic auto-repeat while the key stays held. Characters are queued in a first-word-fall-through FIFO and presented to the consumer over a valid/ready handshake. Overflow is reported with a sticky flag.

---
 rtl/key_char_fifo_if.sv | 41 ++++
 rtl/key_char_fifo.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/key_char_fifo_if.sv
// key_char_fifo_if: keystroke input side and character output handshake of key_char_fifo.
// The slave modport is the buffer itself; the master modport is the surrounding logic.
interface key_char_fifo_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [7:0]    key_ascii;
    logic          key_press;
    logic          key_held;
    logic          clear;
    logic [7:0]    out_ascii;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          overflow;

    modport master (
        output key_ascii,
        output key_press,
        output key_held,
        output clear,
        output out_ready,
        input  out_ascii,
        input  out_valid,
        input  count,
        input  overflow
    );

    modport slave (
        input  key_ascii,
        input  key_press,
        input  key_held,
        input  clear,
        input  out_ready,
        output out_ascii,
        output out_valid,
        output count,
        output overflow
    );
endinterface

// File: rtl/key_char_fifo.sv
// key_char_fifo: buffers decoded keystrokes, generates typematic auto-repeat while a key is
// held, and presents characters through a first-word-fall-through FIFO with a sticky
// overflow flag. The interface instance must use the same DEPTH as this module.
module key_char_fifo #(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
    input logic            clk,
    input logic            rst,
    key_char_fifo_if.slave bus
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = $clog2(DEPTH) + 1;
    localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRepeat
    } state_e;

    state_e        state;
    logic [TW-1:0] timer;
    logic [7:0]    rep_char;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    logic          key_push;
    logic          timer_push;
    logic          push_req;
    logic [7:0]    push_data;
    logic          pop;
    logic          accept;

    // Push/pop decode: a real key press wins over a repeat, and clear suppresses everything.
    always_comb begin
        key_push   = bus.key_press && (bus.key_ascii != 8'h00);
        timer_push = bus.key_held &&
                     (((state == StDelay)  && (timer == DELAY_LAST)) ||
                      ((state == StRepeat) && (timer == PERIOD_LAST)));
        push_req   = !bus.clear && (key_push || timer_push);
        push_data  = key_push ? bus.key_ascii : rep_char;
        pop        = !bus.clear && (count != '0) && bus.out_ready;
        // A full FIFO still takes a push when the head leaves in the same cycle.
        accept     = push_req && ((count != FULL_COUNT) || pop);
    end

    // Typematic repeat FSM: press restarts the delay, release always returns to idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= StIdle;
            timer    <= '0;
            rep_char <= 8'h00;
        end else if (bus.clear) begin
            state <= StIdle;
            timer <= '0;
        end else if (key_push) begin
            rep_char <= bus.key_ascii;
            timer    <= '0;
            state    <= StDelay;
        end else begin
            case (state)
                StIdle: begin
                    timer <= '0;
                end
                StDelay: begin
                    if (!bus.key_held) begin
                        state <= StIdle;
                    end else if (timer == DELAY_LAST) begin
                        timer <= '0;
                        state <= StRepeat;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                StRepeat: begin
                    if (!bus.key_held) begin
                        state <= StIdle;
                    end else if (timer == PERIOD_LAST) begin
                        timer <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state <= StIdle;
                    timer <= '0;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy and sticky overflow; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_req && !accept) begin
                overflow <= 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Character storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign bus.out_valid = (count != '0);
    assign bus.out_ascii = (count != '0) ? mem[rd_ptr] : 8'h00;
    assign bus.count     = count;
    assign bus.overflow  = overflow;
endmodule
